// File: rtl/min_queue_pkg.sv
// Shared definitions for the min-queue: record geometry, key extraction and
// the FIFO minimum-scan state encoding.
package min_queue_pkg;

    localparam int REC_WD = 48;
    localparam int KEY_WD = 16;

    typedef logic [REC_WD-1:0] record_t;
    typedef logic [KEY_WD-1:0] key_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } scan_state_e;

    // The key occupies the top bits of the record; smaller is higher priority.
    function automatic key_t rec_key(input record_t rec);
        return rec[REC_WD-1 -: KEY_WD];
    endfunction

endpackage

// File: rtl/fifo_min_scanner.sv
// Walks the FIFO contents one entry per cycle, oldest first, and registers the
// minimum-key record; any change to the contents restarts the walk.
module fifo_min_scanner
    import min_queue_pkg::*;
#(
    parameter int PTR_WD = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            contents_change,
    input  logic            compare_queue,
    input  logic [PTR_WD-1:0] start_idx,
    input  logic [PTR_WD:0]   start_count,
    output logic [PTR_WD-1:0] scan_idx,
    input  record_t         scan_rec,
    output record_t         min_record,
    output logic            min_val
);

    scan_state_e       state;
    logic [PTR_WD:0]   scan_left;
    logic              first;
    logic              restart;

    assign restart = contents_change || !compare_queue;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state      <= ST_IDLE;
            scan_idx   <= '0;
            scan_left  <= '0;
            first      <= 1'b0;
            min_record <= '0;
            min_val    <= 1'b0;
        end else if (restart) begin
            // Start positions are the post-edge head and count.
            min_val   <= 1'b0;
            scan_idx  <= start_idx;
            scan_left <= start_count;
            first     <= 1'b1;
            state     <= (start_count != '0) ? ST_SCAN : ST_IDLE;
        end else begin
            case (state)
                ST_SCAN: begin
                    // Strict compare keeps the oldest entry on equal keys.
                    if (first || (rec_key(scan_rec) < rec_key(min_record))) begin
                        min_record <= scan_rec;
                    end
                    first     <= 1'b0;
                    scan_idx  <= scan_idx + 1'b1;
                    scan_left <= scan_left - 1'b1;
                    if (scan_left == 1) begin
                        min_val <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_IDLE, ST_DONE: begin
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fifo_manager.sv
// Input staging FIFO for the min-queue: first-word-fall-through head output
// plus an optional scan that reports the minimum-key record it holds.
module fifo_manager
    import min_queue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PTR_WD = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              push_to_fifo,
    input  logic [REC_WD-1:0] push_record,
    output logic              fifo_full,
    output logic              fifo_empty,
    input  logic              pop_from_fifo,
    output logic [REC_WD-1:0] pop_record,
    input  logic              compare_queue,
    output logic [REC_WD-1:0] fifo_min_record,
    output logic              fifo_min_val
);

    localparam logic [PTR_WD:0] FULL_COUNT = (PTR_WD+1)'(DEPTH);

    record_t           mem [DEPTH];
    logic [PTR_WD-1:0] wr_ptr;
    logic [PTR_WD-1:0] rd_ptr;
    logic [PTR_WD-1:0] rd_ptr_nxt;
    logic [PTR_WD-1:0] scan_idx;
    logic [PTR_WD:0]   count;
    logic [PTR_WD:0]   count_nxt;
    logic              pop_acc;
    logic              push_acc;
    logic              contents_change;
    record_t           min_record;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);

    // A pop frees a slot on the same edge, so a full FIFO can still accept.
    assign pop_acc  = pop_from_fifo && !fifo_empty;
    assign push_acc = push_to_fifo && (!fifo_full || pop_acc);
    assign contents_change = push_acc || pop_acc;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (pop_acc) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
        case ({push_acc, pop_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= push_record;
        end
    end

    assign pop_record = mem[rd_ptr];

    fifo_min_scanner #(
        .PTR_WD (PTR_WD)
    ) u_scanner (
        .clk             (clk),
        .rst_b           (rst_b),
        .contents_change (contents_change),
        .compare_queue   (compare_queue),
        .start_idx       (rd_ptr_nxt),
        .start_count     (count_nxt),
        .scan_idx        (scan_idx),
        .scan_rec        (mem[scan_idx]),
        .min_record      (min_record),
        .min_val         (fifo_min_val)
    );

    assign fifo_min_record = min_record;

endmodule

// File: tb/tb_fifo_manager.sv
// Self-checking bench for fifo_manager: vector table for basic push/pop flags,
// a record scoreboard for pop order, and hand sequences for the minimum scan.
module tb_fifo_manager;
    import min_queue_pkg::*;

    localparam int DEPTH  = 16;
    localparam int PTR_WD = 4;

    logic    clk = 1'b0;
    logic    rst_b;
    logic    push_to_fifo;
    record_t push_record;
    logic    fifo_full;
    logic    fifo_empty;
    logic    pop_from_fifo;
    record_t pop_record;
    logic    compare_queue;
    record_t fifo_min_record;
    logic    fifo_min_val;

    fifo_manager #(
        .DEPTH  (DEPTH),
        .PTR_WD (PTR_WD)
    ) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .push_to_fifo    (push_to_fifo),
        .push_record     (push_record),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .pop_from_fifo   (pop_from_fifo),
        .pop_record      (pop_record),
        .compare_queue   (compare_queue),
        .fifo_min_record (fifo_min_record),
        .fifo_min_val    (fifo_min_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic    push;
        record_t rec;
        logic    pop;
        logic    cq;
        logic    exp_empty;
        logic    exp_full;
    } vec_t;

    int      n_tests = 0;
    int      n_fail  = 0;
    record_t model_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Oldest record with the smallest key among the modelled contents.
    function automatic record_t model_min();
        record_t m;
        m = model_q[0];
        foreach (model_q[i]) begin
            if (rec_key(model_q[i]) < rec_key(m)) m = model_q[i];
        end
        return m;
    endfunction

    // Drives one cycle of inputs, checks the head against the scoreboard when
    // a pop is accepted, and returns #1 after the clock edge.
    task automatic cycle(input logic push, input record_t rec, input logic pop, input logic cq);
        bit pop_ok;
        bit push_ok;
        push_to_fifo  = push;
        push_record   = rec;
        pop_from_fifo = pop;
        compare_queue = cq;
        pop_ok  = pop && (model_q.size() > 0);
        push_ok = push && ((model_q.size() < DEPTH) || pop_ok);
        if (pop_ok) check("pop_record", pop_record, model_q[0]);
        @(posedge clk);
        #1;
        if (pop_ok) void'(model_q.pop_front());
        if (push_ok) model_q.push_back(rec);
    endtask

    // Idle for n cycles; fifo_min_val must rise exactly on the n-th edge.
    task automatic wait_min(input int n, input string name);
        for (int k = 1; k <= n; k++) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            check(name, fifo_min_val, (k == n));
        end
        check({name, "_rec"}, fifo_min_record, model_min());
    endtask

    task automatic do_reset();
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b0;
        model_q.delete();
    endtask

    vec_t vecs[5];
    bit   seen_val;

    initial begin
        rst_b         = 1'b0;
        push_to_fifo  = 1'b0;
        push_record   = '0;
        pop_from_fifo = 1'b0;
        compare_queue = 1'b0;

        vecs[0] = '{1'b1, 48'hAAAA_0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 48'h1111_0000_0002, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 48'h0,              1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 48'h0,              1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 48'h0,              1'b1, 1'b0, 1'b1, 1'b0};

        do_reset();
        check("reset_empty", fifo_empty, 1'b1);
        check("reset_full", fifo_full, 1'b0);
        check("reset_min_val", fifo_min_val, 1'b0);
        check("reset_min_rec", fifo_min_record, 48'h0);

        // Basic push/pop ordering and flags.
        for (int i = 0; i < 5; i++) begin
            cycle(vecs[i].push, vecs[i].rec, vecs[i].pop, vecs[i].cq);
            check($sformatf("vec%0d_empty", i), fifo_empty, vecs[i].exp_empty);
            check($sformatf("vec%0d_full", i), fifo_full, vecs[i].exp_full);
            if (i == 0) check("vec0_head", pop_record, 48'hAAAA_0000_0001);
        end

        // Fill, drop on full, push+pop on full, drain across the wrap.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, record_t'(i), 1'b0, 1'b0);
            check("fill_full", fifo_full, (i == DEPTH - 1));
        end
        cycle(1'b1, 48'h99, 1'b0, 1'b0);
        check("drop_full", fifo_full, 1'b1);
        check("drop_head", pop_record, 48'h0);
        cycle(1'b1, 48'h100, 1'b1, 1'b0);
        check("pushpop_full", fifo_full, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain_empty", fifo_empty, 1'b1);
        check("drain_model", model_q.size(), 0);

        // Minimum scan with a tie on the minimum key.
        cycle(1'b1, 48'h0030_0000_0001, 1'b0, 1'b1);
        cycle(1'b1, 48'h0010_0000_0002, 1'b0, 1'b1);
        cycle(1'b1, 48'h0020_0000_0003, 1'b0, 1'b1);
        cycle(1'b1, 48'h0010_0000_0004, 1'b0, 1'b1);
        check("scan4_start", fifo_min_val, 1'b0);
        wait_min(4, "scan4");
        check("scan4_tie", fifo_min_record, 48'h0010_0000_0002);

        // A push while valid clears and rescans; so does a pop.
        cycle(1'b1, 48'h0005_0000_0005, 1'b0, 1'b1);
        check("push_clear", fifo_min_val, 1'b0);
        wait_min(5, "scan5");
        check("scan5_key", fifo_min_record, 48'h0005_0000_0005);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("pop_clear", fifo_min_val, 1'b0);
        wait_min(4, "scan_after_pop");

        // compare_queue low holds the scan off; raising it starts a full walk.
        seen_val = 1'b0;
        repeat (8) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            seen_val |= fifo_min_val;
        end
        check("cq_low_no_val", seen_val, 1'b0);
        wait_min(4, "cq_raise");

        // Empty FIFO never reports a minimum.
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b1);
        check("empty_again", fifo_empty, 1'b1);
        seen_val = 1'b0;
        repeat (20) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            seen_val |= fifo_min_val;
        end
        check("empty_no_val", seen_val, 1'b0);

        // Asynchronous reset in the middle of a scan.
        cycle(1'b1, 48'h0003_0000_0001, 1'b0, 1'b1);
        cycle(1'b1, 48'h0002_0000_0002, 1'b0, 1'b1);
        cycle(1'b1, 48'h0001_0000_0003, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        #2;
        rst_b = 1'b1;
        #1;
        check("async_empty", fifo_empty, 1'b1);
        check("async_full", fifo_full, 1'b0);
        check("async_min_val", fifo_min_val, 1'b0);
        check("async_min_rec", fifo_min_record, 48'h0);
        rst_b = 1'b0;
        model_q.delete();
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("pop_on_empty", fifo_empty, 1'b1);
        repeat (5) cycle(1'b0, '0, 1'b0, 1'b1);
        check("post_reset_no_val", fifo_min_val, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
